// File: rtl/alu_dispatch.sv
// Sequential dispatch front end for a 32-bit combinational ALU with a 32-entry register file.
// Optional debug read port enabled by defining ALU_DISPATCH_DBG_EN.
module alu_dispatch #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic             in_imm_en,
  input  logic [WIDTH-1:0] in_imm,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_x,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rd,
  output logic [WIDTH-1:0] out_x,
  output logic             out_zero,
  output logic             out_err
`ifdef ALU_DISPATCH_DBG_EN
  ,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
`endif
);

  // state | meaning
  // IDLE  | ready to accept an instruction
  // READ  | read operands, load ALU input registers
  // EXEC  | ALU inputs stable; capture result, write back
  // RESP  | response presented until out_ready
  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [4:0]         rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic               imm_en_q, imm_en_d;
  logic [WIDTH-1:0]   imm_q, imm_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [WIDTH-1:0]   out_x_q, out_x_d;
  logic               out_zero_q, out_zero_d;
  logic               out_err_q, out_err_d;
  logic [4:0]         out_rd_q, out_rd_d;
  logic [WIDTH-1:0]   regs_q [NREG];
  logic [WIDTH-1:0]   regs_d [NREG];
  logic [WIDTH-1:0]   rd_a, rd_b;
  logic               op_legal;

  assign rd_a = (rs_q == 5'd0) ? '0 : regs_q[rs_q];
  assign rd_b = (rt_q == 5'd0) ? '0 : regs_q[rt_q];

  always_comb begin
    case (op_q)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    imm_en_d   = imm_en_q;
    imm_d      = imm_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    out_x_d    = out_x_q;
    out_zero_d = out_zero_q;
    out_err_d  = out_err_q;
    out_rd_d   = out_rd_q;
    regs_d     = regs_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d     = in_op;
          rs_d     = in_rs;
          rt_d     = in_rt;
          rd_d     = in_rd;
          imm_en_d = in_imm_en;
          imm_d    = in_imm;
          state_d  = READ;
        end
      end
      READ: begin
        // ALU inputs are registered here so they are stable for all of EXEC
        alu_op_d = op_q;
        alu_a_d  = rd_a;
        alu_b_d  = imm_en_q ? imm_q : rd_b;
        state_d  = EXEC;
      end
      EXEC: begin
        out_rd_d = rd_q;
        if (op_legal) begin
          out_x_d    = alu_x;
          out_zero_d = alu_zero;
          out_err_d  = 1'b0;
          if (rd_q != 5'd0) regs_d[rd_q] = alu_x;
        end else begin
          out_x_d    = '0;
          out_zero_d = 1'b0;
          out_err_d  = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      imm_en_q   <= 1'b0;
      imm_q      <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      out_x_q    <= '0;
      out_zero_q <= 1'b0;
      out_err_q  <= 1'b0;
      out_rd_q   <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      imm_en_q   <= imm_en_d;
      imm_q      <= imm_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      out_x_q    <= out_x_d;
      out_zero_q <= out_zero_d;
      out_err_q  <= out_err_d;
      out_rd_q   <= out_rd_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RESP);
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out_x     = out_x_q;
  assign out_zero  = out_zero_q;
  assign out_err   = out_err_q;
  assign out_rd    = out_rd_q;

`ifdef ALU_DISPATCH_DBG_EN
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural ALU; register contents are read back
// through non-writing ADD rd=0 instructions, plus dbg_data when ALU_DISPATCH_DBG_EN is defined.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_imm_en;
  logic [31:0] in_imm;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_x;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_x;
  logic        out_zero, out_err;
`ifdef ALU_DISPATCH_DBG_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_dispatch #(.WIDTH(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_x(alu_x), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_x(out_x), .out_zero(out_zero), .out_err(out_err)
`ifdef ALU_DISPATCH_DBG_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
  );

  // behavioural ALU; illegal opcodes return a marker that the dispatcher must discard
  always_comb begin
    case (alu_op)
      3'b000:  alu_x = alu_a & alu_b;
      3'b001:  alu_x = alu_a | alu_b;
      3'b010:  alu_x = alu_a + alu_b;
      3'b110:  alu_x = alu_a - alu_b;
      3'b111:  alu_x = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_x = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_x == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [2:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic ie,
                      input logic [31:0] imm);
    int n;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm_en = ie; in_imm = imm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_imm = 32'h5A5A_0F0F;
    n = 1;
    while (out_valid !== 1'b1 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
  endtask

  task automatic complete(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd, input logic ie,
                     input logic [31:0] imm, input logic [31:0] ex, input logic ez,
                     input logic eerr);
    send(tag, op, rs, rt, rd, ie, imm);
    chk({tag, "_x"},    out_x,              ex);
    chk({tag, "_zero"}, {31'd0, out_zero},  {31'd0, ez});
    chk({tag, "_err"},  {31'd0, out_err},   {31'd0, eerr});
    chk({tag, "_rd"},   {27'd0, out_rd},    {27'd0, rd});
    complete(tag);
  endtask

  task automatic readreg(input string tag, input logic [4:0] r, input logic [31:0] ex);
    run(tag, 3'b010, r, 5'd0, 5'd0, 1'b1, 32'd0, ex, (ex == 32'd0), 1'b0);
`ifdef ALU_DISPATCH_DBG_EN
    dbg_addr = r; #1;
    chk({tag, "_dbg"}, dbg_data, ex);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm_en = 1'b0; in_imm = '0; out_ready = 1'b0;
`ifdef ALU_DISPATCH_DBG_EN
    dbg_addr = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_x",     out_x,              32'd0);
    chk("rst_out_err",   {31'd0, out_err},   32'd0);
    chk("rst_alu_op",    {29'd0, alu_op},    32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("add_imm", 3'b010, 5'd0, 5'd0, 5'd1, 1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
    chk("hold_alu_op", {29'd0, alu_op}, 32'd2);
    chk("hold_alu_a",  alu_a, 32'd0);
    chk("hold_alu_b",  alu_b, 32'd9);
    readreg("r1", 5'd1, 32'd9);

    run("and_imm", 3'b000, 5'd1, 5'd0, 5'd2, 1'b1, 32'd8,  32'd8,  1'b0, 1'b0);
    run("or_imm",  3'b001, 5'd1, 5'd0, 5'd3, 1'b1, 32'd12, 32'd13, 1'b0, 1'b0);
    run("add_reg", 3'b010, 5'd2, 5'd3, 5'd4, 1'b0, 32'd100, 32'd21, 1'b0, 1'b0);
    run("sub_zero", 3'b110, 5'd1, 5'd0, 5'd5, 1'b1, 32'd9, 32'd0, 1'b1, 1'b0);
    run("slt_lt",  3'b111, 5'd0, 5'd1, 5'd6, 1'b0, 32'd0, 32'd1, 1'b0, 1'b0);
    run("slt_ge",  3'b111, 5'd1, 5'd0, 5'd6, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    readreg("r4", 5'd4, 32'd21);

    run("add_r0", 3'b010, 5'd1, 5'd0, 5'd0, 1'b1, 32'd1, 32'd10, 1'b0, 1'b0);
    readreg("r0", 5'd0, 32'd0);

    run("set_r7", 3'b010, 5'd0, 5'd0, 5'd7, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0);

    // stall in RESP while a second instruction is offered and must be dropped
    send("stall", 3'b010, 5'd1, 5'd0, 5'd8, 1'b1, 32'd1);
    in_op = 3'b010; in_rs = 5'd0; in_rd = 5'd9; in_imm_en = 1'b1; in_imm = 32'd77;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_x",     out_x,              32'd10);
      chk("stall_rd",    {27'd0, out_rd},    32'd8);
      chk("stall_ready", {31'd0, in_ready},  32'd0);
    end
    in_valid = 1'b0;
    complete("stall");
    readreg("r8", 5'd8, 32'd10);
    readreg("r9_lost", 5'd9, 32'd0);

    run("illegal", 3'b011, 5'd1, 5'd0, 5'd7, 1'b1, 32'd1, 32'd0, 1'b0, 1'b1);
    readreg("r7_kept", 5'd7, 32'd5);

    // reset during EXEC of ADD rd=1
    in_op = 3'b010; in_rs = 5'd0; in_rd = 5'd1; in_imm_en = 1'b1; in_imm = 32'd50;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_alu_b", alu_b, 32'd50);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready},  32'd1);
    chk("mid_rst_x",     out_x,              32'd0);
    chk("mid_rst_alu_b", alu_b,              32'd0);
    chk("mid_rst_rd",    {27'd0, out_rd},    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    readreg("r1_after_rst", 5'd1, 32'd0);
    readreg("r7_after_rst", 5'd7, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
